// File: rtl/ahb_sram_slave_if.sv
// AHB slave-port bundle: address/data phase from the interconnect, ready/response/read data back.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: OKAY data phase is WAIT_STATES+1 cycles, ERROR is 2 cycles; stalls the bus via hreadyout.
// Read data is captured at the accepting edge; writes commit at the end of the final data-phase cycle.
module ahb_sram_slave #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          WAIT_STATES = 1
) (
    input logic             hclk,
    input logic             hreset,
    ahb_sram_slave_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_q;
    logic              wr_q;
    logic [3:0]        lanes_q;
    logic [DATA_W-1:0] hrdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [32:0]       offset;
    logic              addr_err;
    logic              accept;
    logic [AW-1:0]     idx_new;
    logic [3:0]        lanes_new;
    logic              commit;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic              hreadyout_c;
    logic [1:0]        hresp_c;
    logic              unused_ok;

    // A 33-bit subtraction borrows into bit 32 when haddr < BASE_ADDR, so one compare covers both bounds.
    always_comb begin
        offset   = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
        addr_err = (offset >= WIN_BYTES)
                 || (bus.hsize > 3'd2)
                 || ((bus.hsize == 3'd1) && bus.haddr[0])
                 || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
        idx_new  = offset[AW+1:2];
        case (bus.hsize)
            3'd0:    lanes_new = 4'b0001 << bus.haddr[1:0];
            3'd1:    lanes_new = bus.haddr[1] ? 4'b1100 : 4'b0011;
            default: lanes_new = 4'b1111;
        endcase
    end

    assign accept = bus.hsel && bus.hready && bus.htrans[1]
                 && ((state == S_IDLE) || (state == S_LAST) || (state == S_ERR2));

    assign commit = (state == S_LAST) && wr_q;

    always_comb begin
        merged = mem[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (lanes_q[b]) begin
                merged[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
    end

    // A read accepted on the committing edge of a write to the same word sees the merged data.
    assign rd_word = (commit && (idx_q == idx_new)) ? merged : mem[idx_new];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LAST, S_ERR2: begin
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (addr_err) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_nxt = S_LAST;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_LAST;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hreadyout_c = 1'b1;
        hresp_c     = 2'b00;
        case (state)
            S_WAIT: hreadyout_c = 1'b0;
            S_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 2'b01;
            end
            S_ERR2: hresp_c = 2'b01;
            default: begin
                hreadyout_c = 1'b1;
                hresp_c     = 2'b00;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt      <= 4'd0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            lanes_q  <= 4'b0000;
            hrdata_q <= '0;
        end else begin
            if (accept && !addr_err && (WAIT_STATES != 0)) begin
                cnt <= WS_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (accept) begin
                idx_q   <= idx_new;
                wr_q    <= bus.hwrite && !addr_err;
                lanes_q <= lanes_new;
                if (!bus.hwrite && !addr_err) begin
                    hrdata_q <= rd_word;
                end
            end
        end
    end

    // Storage is deliberately left unreset; a reset in flight simply drops the pending write.
    always_ff @(posedge hclk) begin
        if (commit && !hreset) begin
            mem[idx_q] <= merged;
        end
    end

    assign bus.hreadyout = hreadyout_c;
    assign bus.hresp     = hresp_c;
    assign bus.hrdata    = hrdata_q;
    assign unused_ok     = bus.htrans[0];

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 and 0 wait states) against a transfer-level memory model.
module tb_ahb_sram_slave;
    localparam logic [31:0] BASE = 32'h4000_0000;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus1();

    ahb_sram_slave #(.DATA_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(1))
        u_ws1 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_sram_slave #(.DATA_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(0))
        u_ws0 (.hclk(hclk), .hreset(hreset), .bus(bus1));

    logic        sel_d   [2];
    logic [1:0]  trans_d [2];
    logic [31:0] addr_d  [2];
    logic        write_d [2];
    logic [2:0]  size_d  [2];
    logic [31:0] wdata_d [2];
    logic        rdy_o   [2];
    logic [1:0]  resp_o  [2];
    logic [31:0] rd_o    [2];

    assign bus0.hsel = sel_d[0];    assign bus1.hsel = sel_d[1];
    assign bus0.htrans = trans_d[0]; assign bus1.htrans = trans_d[1];
    assign bus0.haddr = addr_d[0];  assign bus1.haddr = addr_d[1];
    assign bus0.hwrite = write_d[0]; assign bus1.hwrite = write_d[1];
    assign bus0.hsize = size_d[0];  assign bus1.hsize = size_d[1];
    assign bus0.hwdata = wdata_d[0]; assign bus1.hwdata = wdata_d[1];
    assign bus0.hready = bus0.hreadyout;
    assign bus1.hready = bus1.hreadyout;
    assign rdy_o[0] = bus0.hreadyout; assign rdy_o[1] = bus1.hreadyout;
    assign resp_o[0] = bus0.hresp;    assign resp_o[1] = bus1.hresp;
    assign rd_o[0] = bus0.hrdata;     assign rd_o[1] = bus1.hrdata;

    // Model: per port a byte-addressable memory with known-byte flags and the current data phase.
    int          ws [2];
    logic [31:0] mem_m [2][256];
    logic [3:0]  bk    [2][256];
    bit          dp_act [2];
    bit          dp_err [2];
    bit          dp_wr  [2];
    int          dp_k   [2];
    int          dp_idx [2];
    logic [3:0]  dp_ln  [2];
    logic [31:0] dp_wd  [2];
    logic [31:0] hrd_exp [2];
    logic [31:0] hrd_msk [2];
    logic        smp_rdy [2];
    logic [1:0]  smp_resp [2];
    logic [31:0] smp_rd [2];
    int          wait_cnt [2];
    int          errlo [2];
    int          errhi [2];
    bit          mvalid;
    bit          rand_mode;
    bit          rst_req;
    int          checks;
    int          failures;
    xfer_t       q0[$];
    xfer_t       q1[$];

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s port%0d actual=%h required=%h t=%0t", nm, p, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        return (a < BASE) || ((a - BASE) >= 32'd1024) || (s > 3'd2)
            || ((s == 3'd1) && a[0]) || ((s == 3'd2) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [2:0] s);
        if (s == 3'd0) return 4'b0001 << a[1:0];
        if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.addr = a; x.write = wr; x.size = s; x.wdata = wd;
        return x;
    endfunction

    function automatic xfer_t idle_x(input bit sel);
        xfer_t x;
        x.sel = sel; x.trans = 2'b00; x.addr = $urandom; x.write = 1'($urandom);
        x.size = 3'($urandom); x.wdata = $urandom;
        return x;
    endfunction

    function automatic xfer_t rnd_x();
        xfer_t x;
        int r;
        x.sel = ($urandom_range(99) < 90);
        r = $urandom_range(9);
        x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        r = $urandom_range(9);
        x.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(7, 3));
        r = $urandom_range(19);
        if (r == 0)      x.addr = BASE + 32'h400 + 32'($urandom_range(63));
        else if (r == 1) x.addr = BASE - 32'd4 + 32'($urandom_range(3));
        else begin
            x.addr = BASE + 32'($urandom_range(15) * 4);
            if (x.size == 3'd2 && $urandom_range(3) == 0) x.addr[1:0] = 2'($urandom_range(3));
            else if (x.size == 3'd1) x.addr[1:0] = ($urandom_range(3) == 0) ? 2'b01 : {1'($urandom), 1'b0};
            else if (x.size == 3'd0) x.addr[1:0] = 2'($urandom_range(3));
        end
        x.write = 1'($urandom);
        x.wdata = $urandom;
        return x;
    endfunction

    task automatic push(input int p, input xfer_t x);
        if (p == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic drive(input int p, input xfer_t x);
        sel_d[p] = x.sel; trans_d[p] = x.trans; addr_d[p] = x.addr;
        write_d[p] = x.write; size_d[p] = x.size;
    endtask

    // One bus cycle: compare the visible data-phase outputs, then drive and advance the model past the next edge.
    task automatic step();
        bit    ex_rdy [2];
        int    tot;
        xfer_t x;
        @(negedge hclk);
        for (int p = 0; p < 2; p++) begin
            tot = dp_err[p] ? 2 : ws[p] + 1;
            ex_rdy[p] = !dp_act[p] || (dp_k[p] == tot - 1);
            smp_rdy[p] = rdy_o[p]; smp_resp[p] = resp_o[p]; smp_rd[p] = rd_o[p];
            if (mvalid) begin
                chk("hreadyout", p, {31'b0, smp_rdy[p]}, {31'b0, ex_rdy[p]});
                chk("hresp", p, {30'b0, smp_resp[p]}, (dp_act[p] && dp_err[p]) ? 32'd1 : 32'd0);
                if (hrd_msk[p] != 32'd0)
                    chk("hrdata", p, smp_rd[p] & hrd_msk[p], hrd_exp[p] & hrd_msk[p]);
                if (dp_act[p] && !dp_err[p] && !smp_rdy[p]) wait_cnt[p]++;
                if (smp_resp[p] == 2'b01) begin
                    if (smp_rdy[p]) errhi[p]++;
                    else            errlo[p]++;
                end
            end
        end
        hreset = rst_req;
        for (int p = 0; p < 2; p++) begin
            wdata_d[p] = (dp_act[p] && dp_wr[p]) ? dp_wd[p] : $urandom;
            if (rst_req) begin
                dp_act[p] = 0;
                hrd_exp[p] = 32'h0;
                hrd_msk[p] = 32'hFFFF_FFFF;
                drive(p, idle_x(1'b0));
            end else if (ex_rdy[p]) begin
                if (dp_act[p] && !dp_err[p] && dp_wr[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dp_ln[p][b]) begin
                            mem_m[p][dp_idx[p]][8*b +: 8] = wdata_d[p][8*b +: 8];
                            bk[p][dp_idx[p]][b] = 1'b1;
                        end
                    end
                end
                dp_act[p] = 0;
                if (p == 0) x = (q0.size() > 0) ? q0.pop_front() : idle_x(1'b0);
                else        x = (q1.size() > 0) ? q1.pop_front() : idle_x(1'b0);
                drive(p, x);
                if (x.sel && x.trans[1]) begin
                    dp_act[p] = 1; dp_k[p] = 0;
                    dp_err[p] = is_err(x.addr, x.size);
                    dp_wr[p] = x.write; dp_wd[p] = x.wdata;
                    if (!dp_err[p]) begin
                        dp_idx[p] = int'((x.addr - BASE) >> 2);
                        dp_ln[p] = lanes_of(x.addr, x.size);
                        if (!x.write) begin
                            hrd_exp[p] = mem_m[p][dp_idx[p]];
                            hrd_msk[p] = expand(bk[p][dp_idx[p]]);
                        end
                    end
                end
            end else begin
                dp_k[p]++;
                if (rand_mode && $urandom_range(1) == 1) drive(p, idle_x(1'($urandom)));
            end
        end
        if (rst_req) mvalid = 1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !dp_act[0] && !dp_act[1]) begin
                done = 1;
                break;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    initial begin
        int w0, w1, elo, ehi;
        bit got;
        ws[0] = 1; ws[1] = 0;
        checks = 0; failures = 0; mvalid = 0; rand_mode = 0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 256; i++) begin
                bk[p][i] = 4'b0000;
                mem_m[p][i] = 32'h0;
            end
            dp_act[p] = 0; dp_err[p] = 0; dp_wr[p] = 0; dp_k[p] = 0; dp_idx[p] = 0;
            dp_ln[p] = 4'b0; dp_wd[p] = 32'h0; hrd_exp[p] = 32'h0; hrd_msk[p] = 32'h0;
            wait_cnt[p] = 0; errlo[p] = 0; errhi[p] = 0;
            drive(p, idle_x(1'b0));
            wdata_d[p] = 32'h0;
        end

        rst_req = 1;
        step(); step();
        rst_req = 0;
        for (int i = 0; i < 4; i++) begin
            push(0, idle_x(1'b1));
            push(1, idle_x(1'b1));
        end
        drain();
        step();
        chk("rst_hreadyout", 0, {31'b0, smp_rdy[0]}, 32'd1);
        chk("rst_hresp", 0, {30'b0, smp_resp[0]}, 32'd0);
        chk("rst_hrdata", 0, smp_rd[0], 32'h0);
        chk("rst_hrdata", 1, smp_rd[1], 32'h0);

        w0 = wait_cnt[0];
        push(0, mk(1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF));
        push(0, mk(0, BASE + 32'h10, 3'd2, 32'h0));
        drain();
        chk("wr_rd_data", 0, rd_o[0], 32'hDEAD_BEEF);
        chk("wr_rd_model", 0, hrd_exp[0], 32'hDEAD_BEEF);
        chk("wr_rd_waitcycles", 0, 32'(wait_cnt[0] - w0), 32'd2);

        push(0, mk(1, BASE + 32'h20, 3'd2, 32'h1122_3344));
        push(0, mk(1, BASE + 32'h22, 3'd0, 32'h00AA_0000));
        push(0, mk(1, BASE + 32'h20, 3'd1, 32'h0000_BBCC));
        push(0, mk(0, BASE + 32'h20, 3'd2, 32'h0));
        drain();
        chk("lanes_data", 0, rd_o[0], 32'h11AA_BBCC);
        chk("lanes_model", 0, hrd_exp[0], 32'h11AA_BBCC);

        push(0, mk(1, BASE, 3'd2, 32'hCAFE_F00D));
        drain();
        elo = errlo[0]; ehi = errhi[0];
        push(0, mk(0, BASE + 32'h400, 3'd2, 32'h0));
        push(0, mk(1, BASE + 32'h2, 3'd2, 32'hFFFF_FFFF));
        push(0, mk(0, BASE, 3'd2, 32'h0));
        drain();
        chk("err_first_cycles", 0, 32'(errlo[0] - elo), 32'd2);
        chk("err_second_cycles", 0, 32'(errhi[0] - ehi), 32'd2);
        chk("err_mem_unchanged", 0, rd_o[0], 32'hCAFE_F00D);

        push(1, mk(1, BASE + 32'h30, 3'd2, 32'hA5A5_A5A5));
        push(1, idle_x(1'b1));
        drain();
        w1 = wait_cnt[1];
        push(1, mk(1, BASE + 32'h30, 3'd2, 32'h0000_00FF));
        push(1, mk(0, BASE + 32'h30, 3'd2, 32'h0));
        drain();
        chk("fwd_data", 1, rd_o[1], 32'h0000_00FF);
        chk("fwd_no_wait", 1, 32'(wait_cnt[1] - w1), 32'd0);

        push(0, mk(1, BASE + 32'h40, 3'd2, 32'h5555_AAAA));
        drain();
        push(0, mk(1, BASE + 32'h40, 3'd2, 32'h1234_5678));
        got = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dp_act[0]) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rst_mid_accept actual=none required=accepted t=%0t", $time);
        end
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk("rst_mid_hreadyout", 0, {31'b0, smp_rdy[0]}, 32'd1);
        push(0, mk(0, BASE + 32'h40, 3'd2, 32'h0));
        drain();
        chk("rst_mid_mem", 0, rd_o[0], 32'h5555_AAAA);

        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            if (q0.size() < 2) push(0, rnd_x());
            if (q1.size() < 2) push(1, rnd_x());
            rst_req = ($urandom_range(399) == 0);
            step();
        end
        rst_req = 0;
        rand_mode = 0;
        drain();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB slave-side responder that terminates one slave port of the generated AHB bus: word-organised on-chip memory with programmable wait states, byte/halfword write lanes and a two-cycle ERROR response. It sits behind an `AHB_arbiter_slave_*` output of the interconnect. It samples the arbitrated address phase and drives `hreadyout`, `hresp` and `hrdata` back into the bus read-data mux.

## Interface
- `DATA_W`, 32: data bus width; only 32 supported.
- `DEPTH`, 256: memory depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h4000_0000: byte address of word 0; window size is `DEPTH*4` bytes.
- `WAIT_STATES`, 1: wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
- `hclk`  in  1  bus clock; all logic on rising edge.
- `hreset`  in  1  synchronous, active-high reset.
- `hsel`  in  1  slave select from the decoder.
- `haddr`  in  32  address-phase byte address.
- `htrans`  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 = byte, 1 = halfword, 2 = word.
- `hwdata`  in  32  write data, valid in the data phase.
- `hready`  in  1  bus-level ready; the previous transfer completes when this is high.
- `hreadyout`  out  1  this slave's ready.
- `hresp`  out  2  OKAY=00, ERROR=01 (RETRY and SPLIT are never issued).
- `hrdata`  out  32  read data.

## Operation
- **Accept condition:** `hsel & hready & htrans[1]` at a rising edge. On accept, register the word index, `hwrite`, `hsize`, `haddr[1:0]` and the lane mask.
  - IDLE or BUSY with `hsel`: no transfer; the next data phase is zero-wait OKAY.
- **Error cases:** the accepted transfer gets ERROR if any of these holds:
  - offset `haddr - BASE_ADDR` is ≥ `DEPTH*4`, or `haddr < BASE_ADDR`;
  - `hsize > 2`;
  - misaligned: halfword with `haddr[0]=1`, or word with `haddr[1:0]≠0`.
  - Errored transfers never modify memory.
- **FSM states:**
  - `IDLE`: `hreadyout=1`, `hresp=OKAY`.
  - `WAIT`: `hreadyout=0`, `hresp=OKAY`; a counter loads `WAIT_STATES-1` and decrements.
  - `LAST`: `hreadyout=1`, `hresp=OKAY`; the write commits at the end of this cycle.
  - `ERR1`: `hreadyout=0`, `hresp=ERROR`.
  - `ERR2`: `hreadyout=1`, `hresp=ERROR`.
- **FSM transitions on accept:**
  - error → `ERR1` → `ERR2`;
  - else if `WAIT_STATES=0` → `LAST`;
  - else → `WAIT` until the counter reaches 0, then `LAST`.
  - From `LAST` or `ERR2`: go to the next state on a new accept, else to `IDLE`.
  - Accepts are only evaluated when `hready=1`.
- **Write lanes (little-endian):**
  - byte → lane `haddr[1:0]`;
  - halfword → lanes {1,0} or {3,2} by `haddr[1]`;
  - word → all 4 lanes.
  - `hwdata` is sampled only in the `LAST` cycle.
- **Reads:**
  - `hrdata` is loaded with the full word at the accepting edge and held until the next read accept.
  - `hrdata` is unchanged during write, ERROR and IDLE phases.
- **Forwarding:** a read accepted on the same edge that a write commits to the same word returns the lane-merged new data, not the stale word.
- **Memory:** not reset.

## Timing
- **Reset values:** `hreadyout=1`, `hresp=2'b00`, `hrdata=32'h0`, FSM in `IDLE`, counter 0.
- **Latency:**
  - OKAY data phase lasts `WAIT_STATES+1` cycles.
  - ERROR data phase lasts exactly 2 cycles.
  - Read data is valid in the data-phase cycle where `hreadyout=1`.
- **Pipelining:** back-to-back transfers with no bubble — the address phase of transfer N+1 overlaps the `LAST`/`ERR2` cycle of transfer N.
- **ERROR cancellation:** if the master drives `htrans=IDLE` during `ERR1`, the slave still completes `ERR2`. No accept occurs in `ERR1` because `hready=0`.
- **Reset mid-transfer:** `hreset` at any state returns to `IDLE` next cycle, drops any pending write (memory untouched), and restores the reset output values.
- **Not our data phase:** `hsel=0` with `hready=1` → no accept; `hreadyout` stays 1 in `IDLE`.

## Test plan
- **Reset, then idle:** `hreset` high 2 cycles, then IDLE transfers → `hreadyout=1`, `hresp=00`, `hrdata=0` every cycle.
- **Word write then read, `WAIT_STATES=1`:**
  - Stimulus: write 0xDEADBEEF to 0x4000_0010, then read 0x4000_0010.
  - Each data phase = 1 cycle `hreadyout=0` + 1 cycle `hreadyout=1`; read returns 0xDEADBEEF.
- **Byte and halfword lanes:**
  - Stimulus: word 0x11223344 at 0x4000_0020; byte write 0xAA to 0x4000_0022 (`hwdata`=0x00AA0000); halfword 0xBBCC to 0x4000_0020; read.
  - Read returns 0x11AABBCC.
- **Errors:**
  - Read 0x4000_0400 (out of range, `DEPTH=256`) → `hresp=01` with `hreadyout=0`, then `hresp=01` with `hreadyout=1`.
  - Word write to 0x4000_0002 → same 2-cycle ERROR; memory unchanged.
- **Pipelined read-after-write forwarding, `WAIT_STATES=0`:**
  - Stimulus: NONSEQ write 0x0000_00FF to 0x4000_0030 immediately followed by NONSEQ read of 0x4000_0030.
  - Read returns 0x0000_00FF with no bubble.
- **Reset mid-write:** assert `hreset` during `WAIT` of a write to 0x4000_0040 → next cycle `hreadyout=1`; a later read of 0x4000_0040 returns the pre-write contents.
